// File: rtl/seg_scan_display.sv
// Multiplexed hex seven-segment scanner.
// Double-buffered frames, leading-zero blanking, PWM-style brightness.
module seg_scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic                    lz_en,
  input  logic [2:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int WW = CW + 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [WW-1:0] PS_W    = WW'(PRESCALE);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    slot_end;
  logic                    wrap;

  logic                    pending;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;
  logic                    accept;

  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   lead;
  logic                    zrun;
  logic [WW-1:0]           lhs;
  logic [WW-1:0]           rhs;
  logic                    win;
  logic                    lit;
  logic [6:0]              seg_nx;

  assign slot_end   = (cnt == CNT_MAX);
  assign wrap       = slot_end && (idx == IDX_MAX);
  assign load_ready = !pending;
  assign accept     = load_valid && !pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CW'(1);
      frame_tick <= wrap;
      if (slot_end)
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  // A frame accepted on the wrap cycle itself waits for the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else if (wrap && pending) begin
      pending    <= 1'b0;
      act_data   <= pend_data;
      act_dp     <= pend_dp;
      act_blank  <= pend_blank;
    end else if (accept) begin
      pending    <= 1'b1;
      pend_data  <= load_data;
      pend_dp    <= load_dp;
      pend_blank <= load_blank;
    end
  end

  assign nib = act_data[{idx, 2'b00} +: 4];

  always_comb begin
    zrun = 1'b1;
    lead = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun = zrun && (act_data[4*i +: 4] == 4'h0);
      if (i > 0)
        lead[i] = zrun;
    end
  end

  // Widened so cnt*8 and (bright+1)*PRESCALE never truncate.
  assign lhs = {1'b0, cnt, 3'b000};
  assign rhs = WW'({1'b0, bright} + 4'd1) * PS_W;
  assign win = lhs < rhs;

  assign lit = !act_blank[idx]
            && !(lz_en && lead[idx])
            && win;

  always_comb begin
    seg_nx = 7'h7F;
    unique case (nib)
      4'h0: seg_nx = 7'b1000000;
      4'h1: seg_nx = 7'b1111001;
      4'h2: seg_nx = 7'b0100100;
      4'h3: seg_nx = 7'b0110000;
      4'h4: seg_nx = 7'b0011001;
      4'h5: seg_nx = 7'b0010010;
      4'h6: seg_nx = 7'b0000010;
      4'h7: seg_nx = 7'b1111000;
      4'h8: seg_nx = 7'b0000000;
      4'h9: seg_nx = 7'b0010000;
      4'hA: seg_nx = 7'b0001000;
      4'hB: seg_nx = 7'b0000011;
      4'hC: seg_nx = 7'b1000110;
      4'hD: seg_nx = 7'b0100001;
      4'hE: seg_nx = 7'b0000110;
      4'hF: seg_nx = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (lit) begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= seg_nx;
      dp  <= ~act_dp[idx];
    end else begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display.
// NUM_DIGITS=4, PRESCALE=8: 8-cycle slots, 32-cycle frames.
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int PS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [4*ND-1:0] load_data;
  logic [ND-1:0] load_dp;
  logic [ND-1:0] load_blank;
  logic          lz_en;
  logic [2:0]    bright;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_dp   (load_dp),
    .load_blank(load_blank),
    .lz_en     (lz_en),
    .bright    (bright),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!frame_tick && k < 100);
    if (!frame_tick) check("tick_timeout", 0, 1);
  endtask

  // Outputs sampled here reflect slot i, prescale count c.
  task automatic at(int i, int c);
    wait_tick();
    step(1 + PS*i + c);
  endtask

  task automatic expect_out(string tag, logic [3:0] a, logic [6:0] s, logic d);
    check({tag, "_an"}, an, a);
    check({tag, "_seg"}, seg, s);
    check({tag, "_dp"}, dp, d);
  endtask

  task automatic load_frame(logic [15:0] d, logic [3:0] p, logic [3:0] b);
    wait_tick();
    step(2);
    load_data  = d;
    load_dp    = p;
    load_blank = b;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic lit_in_slot1(output int on, output int right);
    on = 0;
    right = 0;
    wait_tick();
    step(PS);
    for (int c = 0; c < PS; c++) begin
      step();
      if (an != 4'hF) on++;
      if (an == 4'hD) right++;
    end
  endtask

  initial begin
    int k, on, right, bad;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    load_blank = '0;
    lz_en      = 1'b0;
    bright     = 3'd7;
    step(3);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_ready", load_ready, 1'b1);

    rst_n = 1'b1;
    k = 0;
    bad = 0;
    do begin
      step();
      k++;
      if (an != 4'hF) bad++;
    end while (!frame_tick && k < 100);
    check("first_tick_cycles", k, 32);
    k = 0;
    do begin
      step();
      k++;
      if (an != 4'hF) bad++;
    end while (!frame_tick && k < 100);
    check("tick_period", k, 32);
    check("dark_no_load", bad, 0);

    load_frame(16'h12AF, 4'b0010, 4'b0000);
    check("ready_drop", load_ready, 1'b0);
    at(0, 0);
    expect_out("f1_d0", 4'hE, 7'b0001110, 1'b1);
    check("ready_after_commit", load_ready, 1'b1);
    at(1, 0);
    expect_out("f1_d1", 4'hD, 7'b0001000, 1'b0);
    at(2, 0);
    expect_out("f1_d2", 4'hB, 7'b0100100, 1'b1);
    at(3, 3);
    expect_out("f1_d3", 4'h7, 7'b1111001, 1'b1);

    bad = 0;
    wait_tick();
    for (int c = 0; c < 4*PS; c++) begin
      step();
      if (!(an inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF})) bad++;
    end
    check("anode_onehot", bad, 0);

    bright = 3'd1;
    lit_in_slot1(on, right);
    check("bright1_on", on, 2);
    check("bright1_an", right, 2);
    bright = 3'd0;
    lit_in_slot1(on, right);
    check("bright0_on", on, 1);
    bright = 3'd6;
    at(1, 6);
    check("bright6_c6", an, 4'hD);
    at(1, 7);
    check("bright6_c7", an, 4'hF);
    bright = 3'd7;
    at(1, 7);
    check("bright7_c7", an, 4'hD);

    lz_en = 1'b1;
    load_frame(16'h0005, 4'b0000, 4'b0000);
    at(0, 0);
    expect_out("lz_d0", 4'hE, 7'b0010010, 1'b1);
    at(1, 0);
    expect_out("lz_d1", 4'hF, 7'h7F, 1'b1);
    at(3, 0);
    expect_out("lz_d3", 4'hF, 7'h7F, 1'b1);
    lz_en = 1'b0;
    at(3, 0);
    expect_out("nolz_d3", 4'h7, 7'b1000000, 1'b1);
    at(1, 0);
    expect_out("nolz_d1", 4'hD, 7'b1000000, 1'b1);

    load_frame(16'h8888, 4'b1111, 4'b0100);
    at(2, 0);
    expect_out("blank_d2", 4'hF, 7'h7F, 1'b1);
    at(3, 0);
    expect_out("blank_d3", 4'h7, 7'b0000000, 1'b0);

    wait_tick();
    step(2);
    load_data  = 16'h3333;
    load_dp    = 4'b0000;
    load_blank = 4'b0000;
    load_valid = 1'b1;
    step();
    check("hs_first_acc", load_ready, 1'b0);
    load_data = 16'h4444;
    k = 0;
    while (!load_ready && k < 100) begin
      step();
      k++;
    end
    check("hs_ready_at_wrap", frame_tick, 1'b1);
    check("hs_ready_back", load_ready, 1'b1);
    step();
    load_valid = 1'b0;
    check("hs_second_acc", load_ready, 1'b0);
    expect_out("hs_frameA", 4'hE, 7'b0110000, 1'b1);
    at(0, 0);
    expect_out("hs_frameB", 4'hE, 7'b0011001, 1'b1);

    wait_tick();
    step(3);
    load_data  = 16'h5555;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("rst_pend_set", load_ready, 1'b0);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'hF, 7'h7F, 1'b1);
    check("async_rst_ready", load_ready, 1'b1);
    check("async_rst_tick", frame_tick, 1'b0);
    step(2);
    rst_n = 1'b1;
    k = 0;
    bad = 0;
    do begin
      step();
      k++;
      if (an != 4'hF) bad++;
    end while (!frame_tick && k < 100);
    check("rerst_tick_cycles", k, 32);
    for (int c = 0; c < 4*PS; c++) begin
      step();
      if (an != 4'hF) bad++;
    end
    check("rerst_dark", bad, 0);
    check("rerst_ready", load_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
